fp_prenormalize: RTL and testbench

FP_PRENORMALIZE -- requirements
Module: fp_prenormalize

---
 rtl/fpu_types.sv | 39 +++
 rtl/fp_clz.sv | 20 ++
 rtl/fp_prenormalize.sv | 150 +++++++++++++++
 tb/tb_fp_prenormalize.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_types.sv
// Shared FPU types: IEEE double layout, special-case flags and the
// classification helper used by the prenormalization pipeline.
package fpu_types;

    localparam int FLEN       = 64;
    localparam int FRAC_WIDTH = 52;
    localparam int EXPO_WIDTH = 11;
    localparam int BIAS       = 1023;

    typedef struct packed {
        logic                  sign;
        logic [EXPO_WIDTH-1:0] expo;
        logic [FRAC_WIDTH-1:0] frac;
    } fp_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic snan;
        logic qnan;
    } fp_special_case_t;

    typedef logic [EXPO_WIDTH-1:0] fp_shift_amt_t;

    // At most one flag is set; subnormals and normals leave all four clear.
    function automatic fp_special_case_t classify(input fp_t x);
        fp_special_case_t sc;
        logic             expo_max;
        logic             frac_zero;
        expo_max  = &x.expo;
        frac_zero = (x.frac == '0);
        sc.zero   = (x.expo == '0) && frac_zero;
        sc.inf    = expo_max && frac_zero;
        sc.qnan   = expo_max && x.frac[FRAC_WIDTH-1];
        sc.snan   = expo_max && !frac_zero && !x.frac[FRAC_WIDTH-1];
        return sc;
    endfunction

endpackage

// File: rtl/fp_clz.sv
// Parameterized leading-zero counter; an all-zero input yields WIDTH.
module fp_clz #(
    parameter int WIDTH     = 52,
    parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]     value,
    output logic [CNT_WIDTH-1:0] count
);

    // Scan upward so the highest set bit is the last one to update the count.
    always_comb begin
        count = CNT_WIDTH'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_prenormalize.sv
// Two-stage pipeline that classifies both operands and left-justifies
// subnormal fractions ahead of the divider, with valid/ready flow control.
module fp_prenormalize
    import fpu_types::*;
#(
    parameter int FLEN     = fpu_types::FLEN,
    parameter int ID_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLEN-1:0]       in_rs1,
    input  logic [FLEN-1:0]       in_rs2,
    input  logic [2:0]            in_rm,
    input  logic                  in_single,
    input  logic [ID_WIDTH-1:0]   in_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    output fp_t                   out_rs1,
    output fp_t                   out_rs2,
    output logic                  out_rs1_hidden,
    output logic                  out_rs2_hidden,
    output fp_special_case_t      out_rs1_special_case,
    output fp_special_case_t      out_rs2_special_case,
    output fp_shift_amt_t         out_rs1_shift_amt,
    output fp_shift_amt_t         out_rs2_shift_amt,
    output logic [2:0]            out_rm,
    output logic                  out_single,
    output logic [ID_WIDTH-1:0]   out_id
);

    localparam int CLZ_WIDTH = $clog2(FRAC_WIDTH + 1);

    fp_t                  rs1_in;
    fp_t                  rs2_in;
    logic [CLZ_WIDTH-1:0] clz1;
    logic [CLZ_WIDTH-1:0] clz2;

    logic                 s1_valid;
    fp_t                  s1_rs1;
    fp_t                  s1_rs2;
    fp_special_case_t     s1_sc1;
    fp_special_case_t     s1_sc2;
    logic [CLZ_WIDTH-1:0] s1_clz1;
    logic [CLZ_WIDTH-1:0] s1_clz2;
    logic [2:0]           s1_rm;
    logic                 s1_single;
    logic [ID_WIDTH-1:0]  s1_id;

    logic                 s2_valid;
    logic                 s1_advance;
    logic                 s2_advance;

    logic                 sub1;
    logic                 sub2;
    logic [FRAC_WIDTH-1:0] frac1_norm;
    logic [FRAC_WIDTH-1:0] frac2_norm;
    fp_shift_amt_t        shift1;
    fp_shift_amt_t        shift2;

    assign rs1_in = in_rs1;
    assign rs2_in = in_rs2;

    fp_clz #(.WIDTH(FRAC_WIDTH), .CNT_WIDTH(CLZ_WIDTH)) u_clz_rs1 (
        .value (rs1_in.frac),
        .count (clz1)
    );

    fp_clz #(.WIDTH(FRAC_WIDTH), .CNT_WIDTH(CLZ_WIDTH)) u_clz_rs2 (
        .value (rs2_in.frac),
        .count (clz2)
    );

    // A stage moves forward when it is empty or the stage after it moves.
    always_comb begin
        s2_advance = !s2_valid || out_ready;
        s1_advance = !s1_valid || s2_advance;
        in_ready   = s1_advance;
        out_valid  = s2_valid;
    end

    // Subnormals shift by leading zeros plus one so the leading one drops out
    // as the implicit bit; everything else passes its fraction through.
    always_comb begin
        sub1       = (s1_rs1.expo == '0) && (s1_rs1.frac != '0);
        sub2       = (s1_rs2.expo == '0) && (s1_rs2.frac != '0);
        shift1     = '0;
        shift2     = '0;
        frac1_norm = s1_rs1.frac;
        frac2_norm = s1_rs2.frac;
        if (sub1) begin
            shift1     = fp_shift_amt_t'(s1_clz1) + fp_shift_amt_t'(1);
            frac1_norm = s1_rs1.frac << (s1_clz1 + CLZ_WIDTH'(1));
        end
        if (sub2) begin
            shift2     = fp_shift_amt_t'(s1_clz2) + fp_shift_amt_t'(1);
            frac2_norm = s1_rs2.frac << (s1_clz2 + CLZ_WIDTH'(1));
        end
    end

    // Only the valid bits are reset; flush empties both stages at once.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_advance) begin
                s2_valid <= s1_valid;
            end
            if (s1_advance) begin
                s1_valid <= in_valid;
            end
        end
    end

    // Stage 1 captures raw operands, their classification and CLZ results.
    always_ff @(posedge clk) begin
        if (s1_advance && in_valid) begin
            s1_rs1    <= rs1_in;
            s1_rs2    <= rs2_in;
            s1_sc1    <= classify(rs1_in);
            s1_sc2    <= classify(rs2_in);
            s1_clz1   <= clz1;
            s1_clz2   <= clz2;
            s1_rm     <= in_rm;
            s1_single <= in_single;
            s1_id     <= in_id;
        end
    end

    // Stage 2 captures the normalized operands and drives every output.
    always_ff @(posedge clk) begin
        if (s2_advance && s1_valid) begin
            out_rs1              <= '{sign: s1_rs1.sign, expo: s1_rs1.expo, frac: frac1_norm};
            out_rs2              <= '{sign: s1_rs2.sign, expo: s1_rs2.expo, frac: frac2_norm};
            out_rs1_hidden       <= (s1_rs1.expo != '0);
            out_rs2_hidden       <= (s1_rs2.expo != '0);
            out_rs1_special_case <= s1_sc1;
            out_rs2_special_case <= s1_sc2;
            out_rs1_shift_amt    <= shift1;
            out_rs2_shift_amt    <= shift2;
            out_rm               <= s1_rm;
            out_single           <= s1_single;
            out_id               <= s1_id;
        end
    end

endmodule

// File: tb/tb_fp_prenormalize.sv
// Directed bench for fp_prenormalize: table of operands with hand-computed
// normalization results, plus stall, flush and reset sequences.
module tb_fp_prenormalize;
    import fpu_types::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_rs1;
    logic [63:0]      in_rs2;
    logic [2:0]       in_rm;
    logic             in_single;
    logic [2:0]       in_id;
    logic             out_valid;
    logic             out_ready;
    fp_t              out_rs1;
    fp_t              out_rs2;
    logic             out_rs1_hidden;
    logic             out_rs2_hidden;
    fp_special_case_t out_rs1_special_case;
    fp_special_case_t out_rs2_special_case;
    fp_shift_amt_t    out_rs1_shift_amt;
    fp_shift_amt_t    out_rs2_shift_amt;
    logic [2:0]       out_rm;
    logic             out_single;
    logic [2:0]       out_id;

    int checks = 0;
    int errors = 0;

    fp_prenormalize #(.FLEN(64), .ID_WIDTH(3)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_rs1               (in_rs1),
        .in_rs2               (in_rs2),
        .in_rm                (in_rm),
        .in_single            (in_single),
        .in_id                (in_id),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_rs1              (out_rs1),
        .out_rs2              (out_rs2),
        .out_rs1_hidden       (out_rs1_hidden),
        .out_rs2_hidden       (out_rs2_hidden),
        .out_rs1_special_case (out_rs1_special_case),
        .out_rs2_special_case (out_rs2_special_case),
        .out_rs1_shift_amt    (out_rs1_shift_amt),
        .out_rs2_shift_amt    (out_rs2_shift_amt),
        .out_rm               (out_rm),
        .out_single           (out_single),
        .out_id               (out_id)
    );

    always #5 clk = ~clk;

    // One operand and its expected normalization; sc is {zero,inf,snan,qnan}.
    typedef struct {
        logic [63:0] in;
        logic [51:0] frac;
        logic        hid;
        logic [3:0]  sc;
        logic [10:0] sh;
    } op_vec_t;

    op_vec_t ops[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input op_vec_t v);
        return {v.in[63:52], v.frac};
    endfunction

    // Presents one request for a single cycle and waits (bounded) for the result.
    task automatic applyStimulus(input int a, input int b, input logic [2:0] rm,
                                 input logic single, input logic [2:0] id, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_rs1    = ops[a].in;
        in_rs2    = ops[b].in;
        in_rm     = rm;
        in_single = single;
        in_id     = id;
        out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
    endtask

    task automatic checkOutput(input int a, input int b, input logic [2:0] rm,
                               input logic single, input logic [2:0] id, input int lat);
        check("latency", 64'(lat), 64'd2);
        check("out_valid", 64'(out_valid), 64'd1);
        check("rs1_word", out_rs1, exp_word(ops[a]));
        check("rs2_word", out_rs2, exp_word(ops[b]));
        check("rs1_hidden", 64'(out_rs1_hidden), 64'(ops[a].hid));
        check("rs2_hidden", 64'(out_rs2_hidden), 64'(ops[b].hid));
        check("rs1_special", 64'(out_rs1_special_case), 64'(ops[a].sc));
        check("rs2_special", 64'(out_rs2_special_case), 64'(ops[b].sc));
        check("rs1_shift", 64'(out_rs1_shift_amt), 64'(ops[a].sh));
        check("rs2_shift", 64'(out_rs2_shift_amt), 64'(ops[b].sh));
        check("rm", 64'(out_rm), 64'(rm));
        check("single", 64'(out_single), 64'(single));
        check("id", 64'(out_id), 64'(id));
    endtask

    initial begin
        int           lat;
        int           sent;
        int           recv;
        int           seen;
        int           stall_n;
        logic [2:0]   held_id;
        logic [63:0]  held_rs1;

        ops[0]  = '{64'h3FF0000000000000, 52'h0000000000000, 1'b1, 4'b0000, 11'd0};
        ops[1]  = '{64'h0000000000000001, 52'h0000000000000, 1'b0, 4'b0000, 11'd52};
        ops[2]  = '{64'h0008000000000000, 52'h0000000000000, 1'b0, 4'b0000, 11'd1};
        ops[3]  = '{64'h7FF0000000000001, 52'h0000000000001, 1'b1, 4'b0010, 11'd0};
        ops[4]  = '{64'h7FF8000000000000, 52'h8000000000000, 1'b1, 4'b0001, 11'd0};
        ops[5]  = '{64'h8000000000000000, 52'h0000000000000, 1'b0, 4'b1000, 11'd0};
        ops[6]  = '{64'hFFF0000000000000, 52'h0000000000000, 1'b1, 4'b0100, 11'd0};
        ops[7]  = '{64'h0000000000000003, 52'h8000000000000, 1'b0, 4'b0000, 11'd51};
        ops[8]  = '{64'h8004000000000000, 52'h0000000000000, 1'b0, 4'b0000, 11'd2};
        ops[9]  = '{64'h400921FB54442D18, 52'h921FB54442D18, 1'b1, 4'b0000, 11'd0};
        ops[10] = '{64'h000FFFFFFFFFFFFF, 52'hFFFFFFFFFFFFE, 1'b0, 4'b0000, 11'd1};
        ops[11] = '{64'h7FEFFFFFFFFFFFFF, 52'hFFFFFFFFFFFFF, 1'b1, 4'b0000, 11'd0};

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rs1 = '0; in_rs2 = '0; in_rm = '0; in_single = 1'b0; in_id = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Table-driven single requests.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i, (i + 3) % 12, 3'(i), i[0], 3'(i), lat);
            checkOutput(i, (i + 3) % 12, 3'(i), i[0], 3'(i), lat);
        end

        // Stream of 8 back-to-back requests with a 3-cycle stall mid-stream.
        sent = 0; recv = 0; stall_n = 0; held_id = '0; held_rs1 = '0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge clk);
            in_valid  = (sent < 8);
            in_id     = 3'(sent);
            in_rs1    = ops[sent % 12].in;
            in_rs2    = ops[(sent + 1) % 12].in;
            out_ready = !(c >= 4 && c <= 6);
            #1;
            if (out_valid && !out_ready) begin
                stall_n++;
                if (stall_n == 1) begin
                    held_id  = out_id;
                    held_rs1 = out_rs1;
                end else begin
                    check("stall_hold_id", 64'(out_id), 64'(held_id));
                    check("stall_hold_rs1", out_rs1, held_rs1);
                end
                if (stall_n == 3) check("stall_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready) begin
                check("stream_id", 64'(out_id), 64'(recv));
                check("stream_rs1", out_rs1, exp_word(ops[recv % 12]));
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        check("stream_received", 64'(recv), 64'd8);
        check("stream_stall_cycles", 64'(stall_n), 64'd3);

        // Flush with both stages full and a new request offered.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_id = 3'd5; in_rs1 = ops[0].in;
        @(negedge clk);
        in_id = 3'd6;
        @(negedge clk);
        in_id = 3'd7; flush = 1'b1;
        #1;
        check("pre_flush_full", 64'(out_valid), 64'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_output", 64'(seen), 64'd0);

        // One-cycle reset in the middle of a stream.
        @(negedge clk);
        in_valid = 1'b1; in_id = 3'd1;
        @(negedge clk);
        in_id = 3'd2;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mid_no_output", 64'(seen), 64'd0);
        applyStimulus(2, 4, 3'd3, 1'b1, 3'd4, lat);
        checkOutput(2, 4, 3'd3, 1'b1, 3'd4, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
